// File: rtl/mips_instr_encoder.sv
// ---------------------------------------------------------------------------
// mips_instr_encoder
//
// Program-loader front end that turns decoded instruction fields back into
// 32-bit MIPS words and writes them into instruction memory at consecutive
// word addresses. It covers exactly the opcode set the main control decoder
// accepts: R-type, lw, sw, beq, bne, addi, j, jal and jr.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   start             opens a load session (only looked at while idle)
//   in_valid/in_ready field handshake; a transfer is in_valid & in_ready
//   in_kind           0=R 1=LW 2=SW 3=BEQ 4=BNE 5=ADDI 6=J 7=JAL 8=JR
//   in_rs..in_target  raw instruction fields
//   in_last           marks the final instruction of the session
//   imem_we/addr/wdata/ready   write port toward instruction memory
//   busy, done        session status; done is a one-cycle pulse
//   count             number of words written in this session
//   err_illegal_kind  sticky: a kind of 9..15 was offered
//   err_overflow      sticky: the word address wrapped past all-ones
// ---------------------------------------------------------------------------
module mips_instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              err_illegal_kind,
    output logic              err_overflow
);

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

    // Kind codes presented on in_kind
    localparam logic [3:0] K_R    = 4'd0;
    localparam logic [3:0] K_LW   = 4'd1;
    localparam logic [3:0] K_SW   = 4'd2;
    localparam logic [3:0] K_BEQ  = 4'd3;
    localparam logic [3:0] K_BNE  = 4'd4;
    localparam logic [3:0] K_ADDI = 4'd5;
    localparam logic [3:0] K_J    = 4'd6;
    localparam logic [3:0] K_JAL  = 4'd7;
    localparam logic [3:0] K_JR   = 4'd8;

    // Primary opcodes (bits 31:26)
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] FN_JR      = 6'b001000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [31:0]        wdata_q;
    logic               last_q;
    logic [ADDR_W:0]    count_q;
    logic               err_ill_q;
    logic               err_ovf_q;

    logic               kind_ok;
    logic               xfer;
    logic               wr_accept;
    logic [31:0]        enc_word;

    function automatic logic legal_kind(input logic [3:0] kind);
        return (kind <= K_JR);
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op,
                                           input logic [4:0] rs,
                                           input logic [4:0] rt,
                                           input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_type(input logic [5:0] op,
                                           input logic [25:0] target);
        return {op, target};
    endfunction

    // Builds the machine word for one instruction. Fields a kind does not
    // use are simply left out of its layout.
    function automatic logic [31:0] encode(input logic [3:0]  kind,
                                           input logic [4:0]  rs,
                                           input logic [4:0]  rt,
                                           input logic [4:0]  rd,
                                           input logic [4:0]  shamt,
                                           input logic [5:0]  funct,
                                           input logic [15:0] imm,
                                           input logic [25:0] target);
        logic [31:0] w;
        w = 32'h0;
        case (kind)
            K_R:    w = {OP_SPECIAL, rs, rt, rd, shamt, funct};
            K_LW:   w = i_type(OP_LW,   rs, rt, imm);
            K_SW:   w = i_type(OP_SW,   rs, rt, imm);
            K_BEQ:  w = i_type(OP_BEQ,  rs, rt, imm);
            K_BNE:  w = i_type(OP_BNE,  rs, rt, imm);
            K_ADDI: w = i_type(OP_ADDI, rs, rt, imm);
            K_J:    w = j_type(OP_J,   target);
            K_JAL:  w = j_type(OP_JAL, target);
            K_JR:   w = {OP_SPECIAL, rs, 5'd0, 5'd0, 5'd0, FN_JR};
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    assign kind_ok   = legal_kind(in_kind);
    assign xfer      = (state_q == ACCEPT) && in_valid;
    assign wr_accept = (state_q == WRITE) && imem_ready;
    assign enc_word  = encode(in_kind, in_rs, in_rt, in_rd, in_shamt,
                              in_funct, in_imm, in_target);

    // Next-state and state-decoded outputs
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        imem_we  = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = ACCEPT;
                end
            end
            ACCEPT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (kind_ok) begin
                        state_d = WRITE;
                    end else if (in_last) begin
                        // An illegal final kind still closes the session.
                        state_d = DONE;
                    end
                end
            end
            WRITE: begin
                imem_we = 1'b1;
                if (imem_ready) begin
                    state_d = last_q ? DONE : ACCEPT;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, address, word and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= BASE;
            wdata_q   <= 32'h0;
            last_q    <= 1'b0;
            count_q   <= '0;
            err_ill_q <= 1'b0;
            err_ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;

            if ((state_q == IDLE) && start) begin
                addr_q    <= BASE;
                count_q   <= '0;
                err_ill_q <= 1'b0;
                err_ovf_q <= 1'b0;
            end

            if (xfer) begin
                if (kind_ok) begin
                    wdata_q <= enc_word;
                    last_q  <= in_last;
                end else begin
                    err_ill_q <= 1'b1;
                end
            end

            if (wr_accept) begin
                // The address is allowed to wrap; the wrap is flagged but
                // loading carries on from address zero.
                addr_q  <= addr_q + ADDR_ONE;
                count_q <= count_q + CNT_ONE;
                if (&addr_q) begin
                    err_ovf_q <= 1'b1;
                end
            end
        end
    end

    assign imem_addr        = addr_q;
    assign imem_wdata       = wdata_q;
    assign count            = count_q;
    assign err_illegal_kind = err_ill_q;
    assign err_overflow     = err_ovf_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// ---------------------------------------------------------------------------
// Scoreboard bench for mips_instr_encoder (ADDR_W=2 so address wrap is easy
// to reach). The stimulus side pushes expected writes and expected session
// results; a negedge monitor pops and compares whenever the DUT completes
// a memory write or pulses done.
// ---------------------------------------------------------------------------
module tb_mips_instr_encoder;

    localparam int ADDR_W = 2;
    localparam int NADDR  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [3:0]        in_kind = '0;
    logic [4:0]        in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
    logic [5:0]        in_funct = '0;
    logic [15:0]       in_imm = '0;
    logic [25:0]       in_target = '0;
    logic              in_last = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              imem_ready = 1'b1;
    logic              busy, done;
    logic [ADDR_W:0]   count;
    logic              err_illegal_kind, err_overflow;

    mips_instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
        .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .imem_ready(imem_ready),
        .busy(busy), .done(done), .count(count),
        .err_illegal_kind(err_illegal_kind), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [31:0] data;
        bit          ovf;
    } wr_t;

    typedef struct {
        int cnt;
        bit ill;
        bit ovf;
    } sess_t;

    wr_t   wr_q[$];
    sess_t sess_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int m_addr, m_count;
    bit m_ill, m_ovf;

    // memory-side control
    int stall_cnt  = 0;
    bit rand_ready = 1'b0;

    // monitor bookkeeping
    bit mon_en    = 1'b0;
    int n_writes  = 0;
    int we_run    = 0;
    int last_run  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    // Reference encoding straight from the instruction formats, by place value.
    function automatic logic [31:0] ref_encode(input int kind, input int rs, input int rt,
                                               input int rd, input int sh, input int fn,
                                               input int imm, input int tgt);
        int unsigned op;
        int unsigned w;
        case (kind)
            1: op = 35;  // lw
            2: op = 43;  // sw
            3: op = 4;   // beq
            4: op = 5;   // bne
            5: op = 8;   // addi
            6: op = 2;   // j
            7: op = 3;   // jal
            default: op = 0;
        endcase
        if (kind == 0)
            w = rs * (2**21) + rt * (2**16) + rd * (2**11) + sh * (2**6) + fn;
        else if (kind == 8)
            w = rs * (2**21) + 8;
        else if (kind == 6 || kind == 7)
            w = op * (2**26) + tgt;
        else
            w = op * (2**26) + rs * (2**21) + rt * (2**16) + imm;
        return w;
    endfunction

    // Memory ready: forced stalls first, otherwise random or always-ready.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (imem_we && stall_cnt > 0) begin
                imem_ready = 1'b0;
                stall_cnt--;
            end else begin
                imem_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // Monitor
    initial begin
        bit          prev_we = 0, prev_rdy = 0, prev_done = 0, pend_ovf = 0;
        bit          exp_ovf = 0;
        logic [31:0] prev_data = 0;
        int          prev_addr = 0;
        wr_t         e;
        sess_t       s;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev_we = 0; prev_done = 0; pend_ovf = 0; we_run = 0;
                continue;
            end
            if (pend_ovf) begin
                chk("err_overflow_after_write", err_overflow, exp_ovf);
                pend_ovf = 0;
            end
            if (prev_done) begin
                chk("done_one_cycle", {done, busy}, 2'b00);
            end
            if (imem_we) begin
                we_run++;
                chk("in_ready_low_in_write", in_ready, 1'b0);
                if (prev_we && !prev_rdy) begin
                    chk("addr_stable", imem_addr, prev_addr);
                    chk("data_stable", imem_wdata, prev_data);
                end
                if (imem_ready) begin
                    n_writes++;
                    last_run = we_run;
                    we_run   = 0;
                    if (wr_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected",
                                 imem_addr, imem_wdata);
                    end else begin
                        e = wr_q.pop_front();
                        chk("write_addr", imem_addr, e.addr);
                        chk("write_data", imem_wdata, e.data);
                        exp_ovf  = e.ovf;
                        pend_ovf = 1;
                    end
                end
            end
            if (done) begin
                if (sess_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_done: count %0d, no session expected", count);
                end else begin
                    s = sess_q.pop_front();
                    chk("done_count", count, s.cnt);
                    chk("done_err_illegal", err_illegal_kind, s.ill);
                    chk("done_err_overflow", err_overflow, s.ovf);
                    chk("done_no_we", imem_we, 1'b0);
                end
            end
            prev_we   = imem_we;
            prev_rdy  = imem_ready;
            prev_addr = imem_addr;
            prev_data = imem_wdata;
            prev_done = done;
        end
    end

    task automatic start_session();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        m_addr = 0; m_count = 0; m_ill = 0; m_ovf = 0;
    endtask

    task automatic issue(input int kind, input int rs, input int rt, input int rd,
                         input int sh, input int fn, input int imm, input int tgt,
                         input bit last, input bit use_lit, input logic [31:0] lit);
        bit  got = 0;
        wr_t e;
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_kind   = 4'(kind);
        in_rs     = 5'(rs);
        in_rt     = 5'(rt);
        in_rd     = 5'(rd);
        in_shamt  = 5'(sh);
        in_funct  = 6'(fn);
        in_imm    = 16'(imm);
        in_target = 26'(tgt);
        in_last   = last;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            timeout_fail("handshake");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (kind <= 8) begin
            e.addr = m_addr;
            e.data = use_lit ? lit : ref_encode(kind, rs, rt, rd, sh, fn, imm, tgt);
            if (m_addr == NADDR - 1) m_ovf = 1;
            e.ovf  = m_ovf;
            m_addr = (m_addr + 1) % NADDR;
            m_count++;
            wr_q.push_back(e);
        end else begin
            m_ill = 1;
        end
        if (last) sess_q.push_back('{m_count, m_ill, m_ovf});
    endtask

    task automatic wait_idle(input string name);
        bit ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout_fail(name);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_we"}, imem_we, 1'b0);
        chk({tag, "_addr"}, imem_addr, 0);
        chk({tag, "_wdata"}, imem_wdata, 32'h0);
        chk({tag, "_ctrl"}, {in_ready, busy, done}, 3'b000);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_errs"}, {err_illegal_kind, err_overflow}, 2'b00);
    endtask

    initial begin
        int wr0;
        #200_000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0, len, kind;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        mon_en = 1'b1;

        // 1: single ADDI
        start_session();
        issue(5, 1, 2, 0, 0, 0, 16'h0005, 0, 1, 1, 32'h20220005);
        wait_idle("t1_idle");

        // 2: R then JAL
        start_session();
        issue(0, 1, 2, 3, 0, 6'h20, 0, 0, 0, 1, 32'h00221820);
        issue(7, 0, 0, 0, 0, 0, 0, 26'h0000010, 1, 1, 32'h0C000010);
        wait_idle("t2_idle");

        // 3: LW with three stalled cycles
        stall_cnt = 3;
        wr0 = n_writes;
        start_session();
        issue(1, 3, 4, 0, 0, 0, 16'h0010, 0, 1, 1, 32'h8C640010);
        wait_idle("t3_idle");
        chk("stall_we_cycles", last_run, 4);
        chk("stall_single_write", n_writes - wr0, 1);

        // 4: illegal kind then BEQ
        start_session();
        issue(12, 7, 7, 7, 7, 7, 16'h1234, 0, 0, 0, 32'h0);
        issue(3, 4, 5, 0, 0, 0, 16'hFFFF, 0, 1, 1, 32'h1085FFFF);
        wait_idle("t4_idle");

        // 5: five jumps across the wrap
        start_session();
        for (int i = 0; i < 5; i++)
            issue(6, 0, 0, 0, 0, 0, 0, 100 + i, i == 4, 0, 32'h0);
        wait_idle("t5_idle");

        // 6: reset in the middle of a write
        stall_cnt = 50;
        start_session();
        issue(1, 9, 10, 0, 0, 0, 16'h00AA, 0, 0, 0, 32'h0);
        begin
            bit seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (imem_we) begin seen = 1; break; end
            end
            if (!seen) timeout_fail("t6_write");
        end
        @(posedge clk); #1;
        rst = 1'b1;
        mon_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midwrite_reset");
        rst = 1'b0;
        stall_cnt = 0;
        wr_q.delete();
        sess_q.delete();
        mon_en = 1'b1;
        start_session();
        issue(5, 1, 2, 0, 0, 0, 16'h0005, 0, 1, 1, 32'h20220005);
        wait_idle("t6_idle");

        // Random sessions with random memory backpressure
        rand_ready = 1'b1;
        for (int s = 0; s < 25; s++) begin
            len = $urandom_range(1, 6);
            start_session();
            for (int i = 0; i < len; i++) begin
                kind = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
                issue(kind, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                      $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 65535),
                      $urandom_range(0, (1 << 26) - 1), i == len - 1, 0, 32'h0);
            end
            wait_idle("rand_idle");
        end
        rand_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("writes_drained", wr_q.size(), 0);
        chk("sessions_drained", sess_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
- Sequential encoder that takes decoded instruction fields and builds 32-bit MIPS instruction words; the inverse of the main control decoder.
- Used as a program loader: each encoded word is written into instruction memory at consecutive word addresses before the core runs.
- Supports exactly the opcode set the control decoder accepts: R-type, lw, sw, beq, bne, addi, j, jal, jr.

Parameters:
ADDR_W, 8, instruction-memory word-address width
BASE_ADDR, 0, first word address written after start

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  begin a load session; sampled only in IDLE
in_valid  in  1  instruction fields valid
in_ready  out  1  encoder accepts fields this cycle
in_kind  in  4  0=R 1=LW 2=SW 3=BEQ 4=BNE 5=ADDI 6=J 7=JAL 8=JR; 9-15 illegal
in_rs  in  5  rs field
in_rt  in  5  rt field
in_rd  in  5  rd field
in_shamt  in  5  shamt field
in_funct  in  6  funct field (R only)
in_imm  in  16  immediate/offset (I-type)
in_target  in  26  jump target (J/JAL)
in_last  in  1  final instruction of the session
imem_we  out  1  write strobe
imem_addr  out  ADDR_W  word address
imem_wdata  out  32  encoded word
imem_ready  in  1  memory accepts the write this cycle
busy  out  1  session in progress (any state other than IDLE)
done  out  1  one-cycle pulse at end of session
count  out  ADDR_W+1  words written this session
err_illegal_kind  out  1  sticky; illegal in_kind was seen
err_overflow  out  1  sticky; address wrapped past 2^ADDR_W-1

Behaviour:
- Reset values: all outputs 0. imem_addr=BASE_ADDR. State IDLE.
- FSM states: IDLE, ACCEPT, WRITE, DONE.
- IDLE:
  - On start=1: clear count, err_illegal_kind and err_overflow; set the address to BASE_ADDR; go to ACCEPT.
  - in_ready=0 in this state.
- ACCEPT:
  - in_ready=1.
  - A transfer occurs when in_valid & in_ready.
  - Legal kind: register the encoded word and go to WRITE. imem_we rises on the next cycle, so latency from transfer to strobe is 1 cycle.
  - Illegal kind: set err_illegal_kind. No word is written and the address does not advance. If in_last=1 go to DONE, otherwise stay in ACCEPT.
- WRITE:
  - in_ready=0.
  - imem_we=1, with imem_addr and imem_wdata held stable until imem_ready=1.
  - Cycle with imem_ready=1: advance the address by 1 and increment count.
  - Then go to DONE if the registered last flag is set, otherwise to ACCEPT.
  - In the following cycle imem_we=0.
- Address wrap: all-ones address + 1 -> 0 and sets err_overflow. Writing continues after the wrap.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - count and error flags hold until the next start.
- Encodings (op = bits 31:26):
  - R: {000000, rs, rt, rd, shamt, funct}
  - JR: {000000, rs, 00000, 00000, 00000, 001000}; in_rt, in_rd, in_shamt and in_funct are ignored.
  - LW: op=100011; SW: op=101011; BEQ: op=000100; BNE: op=000101; ADDI: op=001000. All use the {op, rs, rt, imm} layout.
  - J: {000010, target}; JAL: {000011, target}.
- Fields not used by the kind are ignored.
- start outside IDLE is ignored.
- rst=1 in any state aborts immediately: back to IDLE with reset values, and any pending write is dropped (imem_we=0 next cycle).
- busy=1 in ACCEPT, WRITE and DONE.

Test Plan:
1. start, then ADDI rs=1 rt=2 imm=0x0005 with in_last=1, imem_ready=1 -> imem_wdata=0x20220005 at addr 0; done pulse; count=1.
2. R rs=1 rt=2 rd=3 funct=0x20, then JAL target=0x0000010 with last=1 -> words 0x00221820 at addr 0 and 0x0C000010 at addr 1; count=2.
3. LW with imem_ready held low 3 cycles -> imem_we, address and data stable for 4 cycles; in_ready=0 throughout; exactly one write.
4. kind=12 followed by BEQ rs=4 rt=5 imm=0xFFFF last=1 -> err_illegal_kind=1; 0x1085FFFF written at addr 0; count=1.
5. ADDR_W=2, five J instructions -> addresses 0,1,2,3,0; err_overflow=1 after the 4th write; count=5.
6. rst asserted during WRITE -> imem_we=0 and state IDLE next cycle; all outputs at reset values; a new start works normally.
